// File: rtl/butterfly_top.sv
// Four independent radix-4 butterflies over 16 complex lanes with toggle-strobe capture.
// Optional BUTTERFLY_SAT_EN clamps results instead of wrapping them modulo 2^DW.

module butterfly_r4 #(
  parameter int DW = 16
) (
  input  logic [3:0][DW-1:0] x_re,
  input  logic [3:0][DW-1:0] x_im,
  output logic [3:0][DW-1:0] y_re,
  output logic [3:0][DW-1:0] y_im
);
  localparam int XW = DW + 2;
  typedef logic signed [XW-1:0] wide_t;

  function automatic wide_t sx(input logic [DW-1:0] v);
    return wide_t'(signed'(v));
  endfunction

`ifdef BUTTERFLY_SAT_EN
  localparam wide_t MAXV = wide_t'((1 << (DW-1)) - 1);
  localparam wide_t MINV = wide_t'(-(1 << (DW-1)));
  function automatic logic [DW-1:0] fit(input wide_t v);
    if (v > MAXV)      return MAXV[DW-1:0];
    else if (v < MINV) return MINV[DW-1:0];
    else               return v[DW-1:0];
  endfunction
`else
  function automatic logic [DW-1:0] fit(input wide_t v);
    return v[DW-1:0];
  endfunction
`endif

  wide_t s0r, s0i, d0r, d0i, s1r, s1i, d1r, d1i;

  // Pairwise sums/differences (a,c) and (b,d) shared by all four outputs.
  assign s0r = sx(x_re[0]) + sx(x_re[2]);
  assign s0i = sx(x_im[0]) + sx(x_im[2]);
  assign d0r = sx(x_re[0]) - sx(x_re[2]);
  assign d0i = sx(x_im[0]) - sx(x_im[2]);
  assign s1r = sx(x_re[1]) + sx(x_re[3]);
  assign s1i = sx(x_im[1]) + sx(x_im[3]);
  assign d1r = sx(x_re[1]) - sx(x_re[3]);
  assign d1i = sx(x_im[1]) - sx(x_im[3]);

  assign y_re[0] = fit(s0r + s1r);
  assign y_im[0] = fit(s0i + s1i);
  assign y_re[1] = fit(d0r + d1i);
  assign y_im[1] = fit(d0i - d1r);
  assign y_re[2] = fit(s0r - s1r);
  assign y_im[2] = fit(s0i - s1i);
  assign y_re[3] = fit(d0r - d1i);
  assign y_im[3] = fit(d0i + d1r);
endmodule

module butterfly_top #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_input_flag,
  input  logic [DW-1:0] input_real0,  input  logic [DW-1:0] input_real1,
  input  logic [DW-1:0] input_real2,  input  logic [DW-1:0] input_real3,
  input  logic [DW-1:0] input_real4,  input  logic [DW-1:0] input_real5,
  input  logic [DW-1:0] input_real6,  input  logic [DW-1:0] input_real7,
  input  logic [DW-1:0] input_real8,  input  logic [DW-1:0] input_real9,
  input  logic [DW-1:0] input_real10, input  logic [DW-1:0] input_real11,
  input  logic [DW-1:0] input_real12, input  logic [DW-1:0] input_real13,
  input  logic [DW-1:0] input_real14, input  logic [DW-1:0] input_real15,
  input  logic [DW-1:0] input_imag0,  input  logic [DW-1:0] input_imag1,
  input  logic [DW-1:0] input_imag2,  input  logic [DW-1:0] input_imag3,
  input  logic [DW-1:0] input_imag4,  input  logic [DW-1:0] input_imag5,
  input  logic [DW-1:0] input_imag6,  input  logic [DW-1:0] input_imag7,
  input  logic [DW-1:0] input_imag8,  input  logic [DW-1:0] input_imag9,
  input  logic [DW-1:0] input_imag10, input  logic [DW-1:0] input_imag11,
  input  logic [DW-1:0] input_imag12, input  logic [DW-1:0] input_imag13,
  input  logic [DW-1:0] input_imag14, input  logic [DW-1:0] input_imag15,
  output logic [DW-1:0] output_real0,  output logic [DW-1:0] output_real1,
  output logic [DW-1:0] output_real2,  output logic [DW-1:0] output_real3,
  output logic [DW-1:0] output_real4,  output logic [DW-1:0] output_real5,
  output logic [DW-1:0] output_real6,  output logic [DW-1:0] output_real7,
  output logic [DW-1:0] output_real8,  output logic [DW-1:0] output_real9,
  output logic [DW-1:0] output_real10, output logic [DW-1:0] output_real11,
  output logic [DW-1:0] output_real12, output logic [DW-1:0] output_real13,
  output logic [DW-1:0] output_real14, output logic [DW-1:0] output_real15,
  output logic [DW-1:0] output_imag0,  output logic [DW-1:0] output_imag1,
  output logic [DW-1:0] output_imag2,  output logic [DW-1:0] output_imag3,
  output logic [DW-1:0] output_imag4,  output logic [DW-1:0] output_imag5,
  output logic [DW-1:0] output_imag6,  output logic [DW-1:0] output_imag7,
  output logic [DW-1:0] output_imag8,  output logic [DW-1:0] output_imag9,
  output logic [DW-1:0] output_imag10, output logic [DW-1:0] output_imag11,
  output logic [DW-1:0] output_imag12, output logic [DW-1:0] output_imag13,
  output logic [DW-1:0] output_imag14, output logic [DW-1:0] output_imag15
);
  logic [15:0][DW-1:0] in_re, in_im, cap_re, cap_im, bf_re, bf_im, out_re, out_im;
  logic                flag_q, pending, trig;

  assign in_re = {input_real15, input_real14, input_real13, input_real12,
                  input_real11, input_real10, input_real9,  input_real8,
                  input_real7,  input_real6,  input_real5,  input_real4,
                  input_real3,  input_real2,  input_real1,  input_real0};
  assign in_im = {input_imag15, input_imag14, input_imag13, input_imag12,
                  input_imag11, input_imag10, input_imag9,  input_imag8,
                  input_imag7,  input_imag6,  input_imag5,  input_imag4,
                  input_imag3,  input_imag2,  input_imag1,  input_imag0};

  assign trig = new_input_flag ^ flag_q;

  // Instance g receives lanes 4g..4g+3 (low-order slice goes to index 0).
  butterfly_r4 #(.DW(DW)) u_bf [3:0] (
    .x_re(cap_re), .x_im(cap_im), .y_re(bf_re), .y_im(bf_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q  <= 1'b0;
      pending <= 1'b0;
      cap_re  <= '0;
      cap_im  <= '0;
      out_re  <= '0;
      out_im  <= '0;
    end else begin
      flag_q  <= new_input_flag;
      pending <= trig;
      if (trig) begin
        cap_re <= in_re;
        cap_im <= in_im;
      end
      if (pending) begin
        out_re <= bf_re;
        out_im <= bf_im;
      end
    end
  end

  assign {output_real15, output_real14, output_real13, output_real12,
          output_real11, output_real10, output_real9,  output_real8,
          output_real7,  output_real6,  output_real5,  output_real4,
          output_real3,  output_real2,  output_real1,  output_real0} = out_re;
  assign {output_imag15, output_imag14, output_imag13, output_imag12,
          output_imag11, output_imag10, output_imag9,  output_imag8,
          output_imag7,  output_imag6,  output_imag5,  output_imag4,
          output_imag3,  output_imag2,  output_imag1,  output_imag0} = out_im;
endmodule

// File: tb/tb_butterfly_top.sv
// Scoreboard bench for butterfly_top: stimulus pushes hand-computed expectations
// tagged with the cycle they must appear on; a negedge monitor pops and compares.

module tb_butterfly_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag = 1'b0;
  logic [15:0][15:0] in_re, in_im;
  wire  [15:0][15:0] out_re, out_im;

  typedef struct {
    int                due;
    string             name;
    logic [15:0][15:0] re;
    logic [15:0][15:0] im;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   bad;
  bit   drain_to = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  butterfly_top #(.DW(16)) dut (
    .clk(clk), .rst(rst), .new_input_flag(flag),
    .input_real0(in_re[0]),   .input_real1(in_re[1]),   .input_real2(in_re[2]),   .input_real3(in_re[3]),
    .input_real4(in_re[4]),   .input_real5(in_re[5]),   .input_real6(in_re[6]),   .input_real7(in_re[7]),
    .input_real8(in_re[8]),   .input_real9(in_re[9]),   .input_real10(in_re[10]), .input_real11(in_re[11]),
    .input_real12(in_re[12]), .input_real13(in_re[13]), .input_real14(in_re[14]), .input_real15(in_re[15]),
    .input_imag0(in_im[0]),   .input_imag1(in_im[1]),   .input_imag2(in_im[2]),   .input_imag3(in_im[3]),
    .input_imag4(in_im[4]),   .input_imag5(in_im[5]),   .input_imag6(in_im[6]),   .input_imag7(in_im[7]),
    .input_imag8(in_im[8]),   .input_imag9(in_im[9]),   .input_imag10(in_im[10]), .input_imag11(in_im[11]),
    .input_imag12(in_im[12]), .input_imag13(in_im[13]), .input_imag14(in_im[14]), .input_imag15(in_im[15]),
    .output_real0(out_re[0]),   .output_real1(out_re[1]),   .output_real2(out_re[2]),   .output_real3(out_re[3]),
    .output_real4(out_re[4]),   .output_real5(out_re[5]),   .output_real6(out_re[6]),   .output_real7(out_re[7]),
    .output_real8(out_re[8]),   .output_real9(out_re[9]),   .output_real10(out_re[10]), .output_real11(out_re[11]),
    .output_real12(out_re[12]), .output_real13(out_re[13]), .output_real14(out_re[14]), .output_real15(out_re[15]),
    .output_imag0(out_im[0]),   .output_imag1(out_im[1]),   .output_imag2(out_im[2]),   .output_imag3(out_im[3]),
    .output_imag4(out_im[4]),   .output_imag5(out_im[5]),   .output_imag6(out_im[6]),   .output_imag7(out_im[7]),
    .output_imag8(out_im[8]),   .output_imag9(out_im[9]),   .output_imag10(out_im[10]), .output_imag11(out_im[11]),
    .output_imag12(out_im[12]), .output_imag13(out_im[13]), .output_imag14(out_im[14]), .output_imag15(out_im[15])
  );

  function automatic exp_t mk(input string n, input int due);
    exp_t e;
    e.name = n;
    e.due  = due;
    e.re   = '0;
    e.im   = '0;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (drain_to) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations still queued, required 0", q.size());
      drain_to = 1'b0;
    end
    if (q.size() > 0 && q[0].due <= cyc) begin
      m = q.pop_front();
      n_chk++;
      if (m.due != cyc) begin
        n_fail++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", m.name, cyc, m.due);
      end else if (out_re !== m.re || out_im !== m.im) begin
        n_fail++;
        bad = -1;
        for (int l = 15; l >= 0; l--)
          if (out_re[l] !== m.re[l] || out_im[l] !== m.im[l]) bad = l;
        $display("FAIL %s: lane %0d got re=%h im=%h, required re=%h im=%h",
                 m.name, bad, out_re[bad], out_im[bad], m.re[bad], m.im[bad]);
      end
    end
  end

  initial begin
    exp_t e;
    for (int l = 0; l < 16; l++) begin
      in_re[l] = 16'(l + 1);
      in_im[l] = 16'(100 + l);
    end

    // Reset held with nonzero inputs: everything reads zero.
    @(negedge clk);
    q.push_back(mk("reset_hold", cyc + 1));
    @(negedge clk);
    q.push_back(mk("reset_hold2", cyc + 1));
    @(negedge clk);
    rst = 1'b0;
    q.push_back(mk("post_reset0", cyc + 1));
    q.push_back(mk("post_reset1", cyc + 2));
    q.push_back(mk("post_reset2", cyc + 3));
    idle(3);

    // Basic vector, flag 0->1.
    in_re = '0; in_im = '0;
    in_re[0] = 16'd1; in_im[0] = 16'd5;
    in_re[1] = 16'd2; in_im[1] = 16'd6;
    in_re[2] = 16'd3; in_im[2] = 16'd7;
    in_re[3] = 16'd4; in_im[3] = 16'd8;
    flag = 1'b1;
    e = mk("basic", cyc + 2);
    e.re[0] = 16'h000A; e.im[0] = 16'h001A;
    e.re[1] = 16'hFFFC; e.im[1] = 16'h0000;
    e.re[2] = 16'hFFFE; e.im[2] = 16'hFFFE;
    e.re[3] = 16'h0000; e.im[3] = 16'hFFFC;
    q.push_back(e);
    idle(3);

    // Group independence: impulse in group 2, then DC in group 3.
    in_re = '0; in_im = '0;
    in_re[8] = 16'd1;
    flag = 1'b0;
    e = mk("group2_impulse", cyc + 2);
    for (int l = 8; l < 12; l++) e.re[l] = 16'd1;
    q.push_back(e);
    idle(3);
    in_re = '0;
    for (int l = 12; l < 16; l++) in_re[l] = 16'd1;
    flag = 1'b1;
    e = mk("group3_dc", cyc + 2);
    e.re[12] = 16'd4;
    q.push_back(e);
    idle(2);

    // Inputs churn with no toggle: outputs must hold.
    for (int k = 0; k < 5; k++) begin
      for (int l = 0; l < 16; l++) begin
        in_re[l] = 16'($urandom);
        in_im[l] = 16'($urandom);
      end
      e = mk("hold", cyc + 1);
      e.re[12] = 16'd4;
      q.push_back(e);
      @(negedge clk);
    end

    // Toggle 1->0 with b=1 in group 1: X = 1, -j, -1, +j.
    in_re = '0; in_im = '0;
    in_re[5] = 16'd1;
    flag = 1'b0;
    e = mk("toggle_fall", cyc + 2);
    e.re[4] = 16'h0001;
    e.im[5] = 16'hFFFF;
    e.re[6] = 16'hFFFF;
    e.im[7] = 16'h0001;
    q.push_back(e);
    idle(3);

    // Back-to-back: A = (3j,0,0,0), B = (0,0,0,2).
    in_re = '0; in_im = '0;
    in_im[0] = 16'd3;
    flag = 1'b1;
    e = mk("b2b_A", cyc + 2);
    for (int l = 0; l < 4; l++) e.im[l] = 16'd3;
    q.push_back(e);
    @(negedge clk);
    in_re = '0; in_im = '0;
    in_re[3] = 16'd2;
    flag = 1'b0;
    e = mk("b2b_B", cyc + 2);
    e.re[0] = 16'h0002;
    e.im[1] = 16'h0002;
    e.re[2] = 16'hFFFE;
    e.im[3] = 16'hFFFE;
    q.push_back(e);
    e.name = "b2b_B_hold";
    e.due  = cyc + 3;
    q.push_back(e);
    idle(4);

    // Positive and negative overflow in lane 0.
    in_re = '0; in_im = '0;
    for (int l = 0; l < 4; l++) in_re[l] = 16'h7FFF;
    flag = 1'b1;
    e = mk("overflow_pos", cyc + 2);
`ifdef BUTTERFLY_SAT_EN
    e.re[0] = 16'h7FFF;
`else
    e.re[0] = 16'hFFFC;
`endif
    q.push_back(e);
    idle(3);
    for (int l = 0; l < 4; l++) in_re[l] = 16'h8000;
    flag = 1'b0;
    e = mk("overflow_neg", cyc + 2);
`ifdef BUTTERFLY_SAT_EN
    e.re[0] = 16'h8000;
`else
    e.re[0] = 16'h0000;
`endif
    q.push_back(e);
    idle(3);

    // Reset right after a capture: the captured vector is discarded.
    in_re = '0; in_im = '0;
    in_re[0] = 16'd1; in_im[0] = 16'd5;
    in_re[1] = 16'd2; in_im[1] = 16'd6;
    in_re[2] = 16'd3; in_im[2] = 16'd7;
    in_re[3] = 16'd4; in_im[3] = 16'd8;
    flag = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    q.push_back(mk("midop_reset", cyc + 1));
    @(negedge clk);
    // flag stays 1 while flag_q restarts at 0, so the first edge is a toggle.
    rst = 1'b0;
    q.push_back(mk("after_reset_zero", cyc + 1));
    e = mk("first_edge_toggle", cyc + 2);
    e.re[0] = 16'h000A; e.im[0] = 16'h001A;
    e.re[1] = 16'hFFFC; e.im[1] = 16'h0000;
    e.re[2] = 16'hFFFE; e.im[2] = 16'hFFFE;
    e.re[3] = 16'h0000; e.im[3] = 16'hFFFC;
    q.push_back(e);
    e.name = "first_edge_hold";
    e.due  = cyc + 3;
    q.push_back(e);
    idle(3);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      drain_to = 1'b1;
      idle(2);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
